// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined single-precision adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIG_W = MAN_W + 1;   // significand with hidden bit
  localparam int ALN_W = SIG_W + 3;   // aligned field {sig, G, R, S}
  localparam int SUM_W = ALN_W + 1;   // adder result with carry kept

  localparam int               EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam logic [31:0]      QNAN     = 32'h7FC00000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  // Align-stage payload: larger operand A plus B already shifted to A's exponent.
  typedef struct packed {
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic [ALN_W-1:0] sig_b;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
  } s1_t;

  // Add-stage payload: raw sum with carry bit and guard/round/sticky.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W:0]   sig;
    logic [2:0]       grs;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
  } s2_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter for the normalize stage; all-zero input returns W.
// Latency: combinational.
// Backpressure: none (pure function of din).
module fp_lzc #(
  parameter int W  = 28,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-754 single adder (align, add, normalize/round); macro FP_ROUND_NEAREST_EN selects RNE, else truncate.
// Latency: 3 cycles from input transfer to out_valid; throughput 1/cycle.
// Backpressure: whole pipe stalls when out_valid & !out_ready; in_ready = !out_valid | out_ready.
module fp_add_pipe
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] X0,
  input  logic [31:0] Y0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] R
);

  localparam int WIDE_W = SIG_W + ALN_W - 1;
  localparam int LZ_W   = $clog2(SUM_W + 1);

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- S1: classify, swap, align ----------------
  fp_t              x, y, a, b;
  logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, swap;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic [EXP_W-1:0] d;
  logic [WIDE_W-1:0] shifted;
  s1_t              s1_d, s1;
  logic             s1_vld;

  assign x = X0;
  assign y = Y0;

  // Operand classification, magnitude swap and right shift of the smaller significand.
  always_comb begin
    x_zero  = (x.exp == '0);
    y_zero  = (y.exp == '0);
    x_inf   = (x.exp == EXP_MAX) && (x.man == '0);
    y_inf   = (y.exp == EXP_MAX) && (y.man == '0);
    x_nan   = (x.exp == EXP_MAX) && (x.man != '0);
    y_nan   = (y.exp == EXP_MAX) && (y.man != '0);
    swap    = {y.exp, y.man} > {x.exp, x.man};
    a       = swap ? y : x;
    b       = swap ? x : y;
    // Zero exponent means zero: denormal fractions are dropped here.
    sig_a   = (a.exp == '0) ? '0 : {1'b1, a.man};
    sig_b   = (b.exp == '0) ? '0 : {1'b1, b.man};
    d       = a.exp - b.exp;
    shifted = {sig_b, {(ALN_W-1){1'b0}}} >> d;

    s1_d.sign    = a.sign;
    s1_d.eff_sub = a.sign ^ b.sign;
    s1_d.exp     = a.exp;
    s1_d.sig     = sig_a;
    if (d >= EXP_W'(ALN_W - 1))
      s1_d.sig_b = {{(ALN_W-1){1'b0}}, |sig_b};
    else
      s1_d.sig_b = {shifted[WIDE_W-1 -: ALN_W-1], |shifted[SIG_W-1:0]};
    s1_d.is_nan  = x_nan | y_nan | (x_inf & y_inf & (x.sign ^ y.sign));
    s1_d.is_inf  = (x_inf | y_inf) & ~s1_d.is_nan;
    s1_d.is_zero = x_zero & y_zero;
  end

  // ---------------- S2: add / subtract ----------------
  logic [SUM_W-1:0] op_a, op_b, sum;
  s2_t              s2_d, s2;
  logic             s2_vld;

  // A has the larger magnitude, so the subtraction never goes negative.
  always_comb begin
    op_a = {1'b0, s1.sig, 3'b000};
    op_b = {1'b0, s1.sig_b};
    sum  = s1.eff_sub ? (op_a - op_b) : (op_a + op_b);

    s2_d.exp     = s1.exp;
    s2_d.sig     = sum[SUM_W-1:3];
    s2_d.grs     = sum[2:0];
    s2_d.is_nan  = s1.is_nan;
    s2_d.is_inf  = s1.is_inf;
    s2_d.is_zero = s1.is_zero | (sum == '0);
    // Exact cancellation gives +0; only (-0)+(-0) keeps the minus sign.
    s2_d.sign    = (sum == '0) ? (s1.sign & ~s1.eff_sub) : s1.sign;
  end

  // ---------------- S3: normalize, round, pack ----------------
  logic [SUM_W-1:0] sum2;
  logic [LZ_W-1:0]  lz, sh;
  logic [ALN_W-1:0] norm;
  logic [9:0]       exp_n, exp_f;
  logic             underflow, round_up;
  logic [SIG_W-1:0] man_rnd;
  logic [31:0]      res;

  assign sum2 = {s2.sig, s2.grs};

  fp_lzc #(.W(SUM_W)) u_lzc (
    .din (sum2),
    .cnt (lz)
  );

`ifndef FP_ROUND_NEAREST_EN
  // Guard bits carry no weight when truncating.
  logic [2:0] unused_grs;
  assign unused_grs = norm[2:0];
`endif

  // Normalize to a leading one at the top of the 27-bit field, then round and pack.
  always_comb begin
    sh        = lz - LZ_W'(1);
    underflow = 1'b0;
    if (sum2[SUM_W-1]) begin
      norm  = {sum2[SUM_W-1:2], |sum2[1:0]};
      exp_n = {2'b00, s2.exp} + 10'd1;
    end else begin
      norm      = sum2[ALN_W-1:0] << sh;
      exp_n     = {2'b00, s2.exp} - {{(10-LZ_W){1'b0}}, sh};
      underflow = ({{(EXP_W-LZ_W){1'b0}}, sh} >= s2.exp);
    end

`ifdef FP_ROUND_NEAREST_EN
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    round_up = 1'b0;
`endif
    man_rnd = {1'b0, norm[ALN_W-2 -: MAN_W]} + {{MAN_W{1'b0}}, round_up};
    // Rounding carry out of the mantissa leaves man=0 and bumps the exponent.
    exp_f   = exp_n + {9'b0, man_rnd[MAN_W]};

    res = {s2.sign, exp_f[EXP_W-1:0], man_rnd[MAN_W-1:0]};
    if (s2.is_nan)
      res = QNAN;
    else if (s2.is_inf)
      res = {s2.sign, EXP_MAX, {MAN_W{1'b0}}};
    else if (s2.is_zero || underflow)
      res = {s2.sign, {(31){1'b0}}};
    else if (exp_f >= 10'd255)
      res = {s2.sign, EXP_MAX, {MAN_W{1'b0}}};
  end

  // Stage registers: everything moves together on adv, bubbles travel as valid=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1        <= '0;
      s2_vld    <= 1'b0;
      s2        <= '0;
      out_valid <= 1'b0;
      R         <= 32'h0;
    end else if (adv) begin
      s1_vld    <= in_valid;
      if (in_valid) s1 <= s1_d;
      s2_vld    <= s1_vld;
      if (s1_vld) s2 <= s2_d;
      out_valid <= s2_vld;
      if (s2_vld) R <= res;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: arithmetic vectors, latency, stall/backpressure and mid-flight reset.
// Latency: checks the 3-cycle transfer-to-out_valid timing on every single-shot vector.
// Backpressure: drives out_ready low during a stream and checks in_ready and R stability.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X0, Y0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] R;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

`ifdef FP_ROUND_NEAREST_EN
  localparam logic [31:0] TIE_ODD_EXP = 32'h3F800002;
`else
  localparam logic [31:0] TIE_ODD_EXP = 32'h3F800001;
`endif

  fp_add_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X0        (X0),
    .Y0        (Y0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated operation with out_ready held high; checks latency and result.
  task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e);
    int cyc;
    X0 = a;
    Y0 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, 3);
    check(tag, R, e);
    @(posedge clk); #1;
  endtask

  logic [31:0] sx [8];
  logic [31:0] sy [8];
  logic [31:0] se [8];

  initial begin
    int          sent, recv, stale;
    logic        take_in, was_stall;
    logic [31:0] held;

    sx[0] = 32'h3F800000; sy[0] = 32'h3F800000; se[0] = 32'h40000000;
    sx[1] = 32'h3FC00000; sy[1] = 32'h40100000; se[1] = 32'h40700000;
    sx[2] = 32'h40000000; sy[2] = 32'h40400000; se[2] = 32'h40A00000;
    sx[3] = 32'hC0400000; sy[3] = 32'h3F800000; se[3] = 32'hC0000000;
    sx[4] = 32'h41200000; sy[4] = 32'h41200000; se[4] = 32'h41A00000;
    sx[5] = 32'h3F000000; sy[5] = 32'h3E800000; se[5] = 32'h3F400000;
    sx[6] = 32'hBF800000; sy[6] = 32'hBF800000; se[6] = 32'hC0000000;
    sx[7] = 32'h42C80000; sy[7] = 32'hC2C60000; se[7] = 32'h3F800000;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    X0        = '0;
    Y0        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 0);
    check("reset_R", R, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic arithmetic
    run1("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000);
    run1("1p5_plus_2p25", 32'h3FC00000, 32'h40100000, 32'h40700000);
    run1("cancel_to_pz", 32'hBF800000, 32'h3F800000, 32'h00000000);
    run1("neg_zero_sum", 32'h80000000, 32'h80000000, 32'h80000000);
    run1("mixed_zero", 32'h80000000, 32'h00000000, 32'h00000000);

    // Boundaries and specials
    run1("overflow_inf", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    run1("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    run1("nan_in", 32'h7F800001, 32'h3F800000, 32'h7FC00000);
    run1("ninf_plus_fin", 32'hFF800000, 32'h3F800000, 32'hFF800000);
    run1("denorm_flush", 32'h00400000, 32'h3F800000, 32'h3F800000);
    run1("underflow_flush", 32'h00800001, 32'h80800000, 32'h00000000);

    // Rounding
    run1("tie_odd", 32'h3F800001, 32'h33800000, TIE_ODD_EXP);
    run1("tie_even", 32'h3F800000, 32'h33800000, 32'h3F800000);

    // Back-to-back stream with out_ready low in cycles 4..7
    sent      = 0;
    recv      = 0;
    was_stall = 1'b0;
    held      = '0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      in_valid  = (sent < 8);
      X0        = sx[(sent < 8) ? sent : 0];
      Y0        = sy[(sent < 8) ? sent : 0];
      #1;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", {31'b0, in_ready}, 0);
        if (was_stall) check("stall_hold_R", R, held);
        held      = R;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      take_in = in_valid & in_ready;
      if (out_valid && out_ready) begin
        check($sformatf("stream%0d", recv), R, se[recv]);
        recv++;
      end
      @(posedge clk); #1;
      if (take_in) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", sent, 8);
    check("stream_recv", recv, 8);
    repeat (4) @(posedge clk);
    #1;
    check("stream_drained", {31'b0, out_valid}, 0);

    // Reset with two operations in flight
    X0 = 32'h3F800000; Y0 = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    X0 = 32'h40000000; Y0 = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_valid", {31'b0, out_valid}, 1);
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_R", R, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    stale = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("rst_no_stale", stale, 0);
    run1("post_rst", 32'h3FC00000, 32'h40100000, 32'h40700000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
